// File: rtl/crc_hash_pkg.sv
// Shared CRC-32 constants, FSM state type and the reflected single-byte CRC step
// used by the Bloom-filter hash generator.
package crc_hash_pkg;

  localparam int unsigned CRC_W      = 32;
  localparam int unsigned MAX_POLY   = 4;
  localparam logic [CRC_W-1:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_XOROUT = 32'hFFFF_FFFF;

  // Index 0 is the first engine; engines are taken from the table in order.
  localparam logic [MAX_POLY-1:0][CRC_W-1:0] CRC_POLY = {
    32'h8141_41AB, 32'h741B_8CD7, 32'h1EDC_6F41, 32'h04C1_1DB7
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } hash_state_t;

  // Reflected-input CRC step: data bits enter LSB first against the bit-reversed polynomial.
  function automatic logic [CRC_W-1:0] crc32_byte_step(input logic [CRC_W-1:0] crc,
                                                       input logic [7:0]       data,
                                                       input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    logic [CRC_W-1:0] rpoly;
    for (int i = 0; i < int'(CRC_W); i++) rpoly[i] = poly[CRC_W-1-i];
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_multi_step.sv
// Combinational fold of up to BYTES_PER_CLK bytes into one CRC-32 register;
// byte 0 of data_i is folded first, only the first nbytes_i bytes take effect.
module crc32_multi_step
  import crc_hash_pkg::*;
#(
  parameter int unsigned      BYTES_PER_CLK = 1,
  parameter logic [CRC_W-1:0] POLY          = 32'h04C1_1DB7,
  parameter int unsigned      CNT_W         = $clog2(BYTES_PER_CLK + 1)
) (
  input  logic [CRC_W-1:0]           crc_i,
  input  logic [BYTES_PER_CLK*8-1:0] data_i,
  input  logic [CNT_W-1:0]           nbytes_i,
  output logic [CRC_W-1:0]           crc_o
);

  logic [CRC_W-1:0] crc_c;

  always_comb begin
    crc_c = crc_i;
    for (int j = 0; j < int'(BYTES_PER_CLK); j++) begin
      if (CNT_W'(j) < nbytes_i) crc_c = crc32_byte_step(crc_c, data_i[j*8 +: 8], POLY);
    end
  end

  assign crc_o = crc_c;

endmodule

// File: rtl/crc_hash_seq.sv
// Bloom-filter hash generator: iterative multi-polynomial CRC-32 over a BF_N-byte window,
// sliced into HASH_CNT hashes. Define CRC_HASH_STATS_EN to add window/drop counters.
module crc_hash_seq
  import crc_hash_pkg::*;
#(
  parameter int unsigned BF_N          = 4,
  parameter int unsigned MAX_S         = 32,
  parameter int unsigned NPOLY         = 4,
  parameter int unsigned BYTES_PER_CLK = 1,
  parameter int unsigned HASH_CNT      = 10,
  parameter int unsigned HASH_WIDTH    = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [MAX_S*8-1:0]             symbs_data_i,
  input  logic [MAX_S-1:0]               symbs_data_val_i,
  input  logic                           in_val_i,
  output logic                           in_rdy_o,
  output logic [HASH_CNT*HASH_WIDTH-1:0] hash_o,
  output logic                           hash_val_o,
  input  logic                           hash_rdy_i
`ifdef CRC_HASH_STATS_EN
  ,
  output logic [31:0]                    win_cnt_o,
  output logic [31:0]                    drop_cnt_o
`endif
);

  localparam int unsigned NBEAT  = (BF_N + BYTES_PER_CLK - 1) / BYTES_PER_CLK;
  localparam int unsigned LAST_N = BF_N - (NBEAT - 1) * BYTES_PER_CLK;
  localparam int unsigned WIN_W  = NBEAT * BYTES_PER_CLK * 8;
  localparam int unsigned BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned CNT_W  = $clog2(BYTES_PER_CLK + 1);
  localparam int unsigned ALL_W  = CRC_W * NPOLY;
  localparam int unsigned HASH_W = HASH_CNT * HASH_WIDTH;

  if (HASH_W > ALL_W) begin : g_bad_hash
    $error("crc_hash_seq: HASH_CNT*HASH_WIDTH exceeds 32*NPOLY");
  end
  if (NPOLY < 1 || NPOLY > MAX_POLY) begin : g_bad_npoly
    $error("crc_hash_seq: NPOLY out of range");
  end
  if (BF_N < 1 || BF_N > MAX_S || BYTES_PER_CLK < 1 || BYTES_PER_CLK > BF_N) begin : g_bad_win
    $error("crc_hash_seq: BF_N/BYTES_PER_CLK out of range");
  end

  hash_state_t                  state_q;
  logic [WIN_W-1:0]             win_q;
  logic [BEAT_W-1:0]            beat_q;
  logic [NPOLY-1:0][CRC_W-1:0]  crc_q;
  logic [NPOLY-1:0][CRC_W-1:0]  crc_d;
  logic [HASH_W-1:0]            hash_q;
  logic [HASH_W-1:0]            hash_d;
  logic                         hash_val_q;
  logic [WIN_W-1:0]             win_c;
  logic [ALL_W-1:0]             all_c;
  logic                         win_ok_c;
  logic                         last_beat_c;
  logic [CNT_W-1:0]             nbytes_c;
  logic                         unused_c;

  assign win_ok_c    = &symbs_data_val_i[MAX_S-1 -: BF_N];
  assign last_beat_c = (beat_q == BEAT_W'(NBEAT - 1));
  assign nbytes_c    = last_beat_c ? CNT_W'(LAST_N) : CNT_W'(BYTES_PER_CLK);
  assign in_rdy_o    = (state_q == IDLE) | ((state_q == OUT) & hash_rdy_i);
  assign hash_o      = hash_q;
  assign hash_val_o  = hash_val_q;
  assign unused_c    = ^{symbs_data_i, symbs_data_val_i};

  // Oldest symbol byte lands in window byte 0 so it is folded first.
  always_comb begin
    win_c = '0;
    for (int i = 0; i < int'(BF_N); i++) win_c[i*8 +: 8] = symbs_data_i[(MAX_S-1-i)*8 +: 8];
  end

  for (genvar p = 0; p < int'(NPOLY); p++) begin : g_eng
    crc32_multi_step #(
      .BYTES_PER_CLK(BYTES_PER_CLK),
      .POLY         (CRC_POLY[p]),
      .CNT_W        (CNT_W)
    ) u_step (
      .crc_i   (crc_q[p]),
      .data_i  (win_q[BYTES_PER_CLK*8-1:0]),
      .nbytes_i(nbytes_c),
      .crc_o   (crc_d[p])
    );
  end

  // Engine 0 occupies the MSBs; hash 0 is taken from the top of the concatenation.
  always_comb begin
    all_c  = '0;
    hash_d = '0;
    for (int p = 0; p < int'(NPOLY); p++) all_c[CRC_W*(NPOLY-1-p) +: CRC_W] = crc_d[p] ^ CRC_XOROUT;
    for (int k = 0; k < int'(HASH_CNT); k++)
      hash_d[k*HASH_WIDTH +: HASH_WIDTH] = all_c[ALL_W-1-k*HASH_WIDTH -: HASH_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      win_q      <= '0;
      beat_q     <= '0;
      crc_q      <= {NPOLY{CRC_INIT}};
      hash_q     <= '0;
      hash_val_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_val_i && win_ok_c) begin
            state_q <= CALC;
            win_q   <= win_c;
            beat_q  <= '0;
            crc_q   <= {NPOLY{CRC_INIT}};
          end
        end
        CALC: begin
          crc_q  <= crc_d;
          win_q  <= win_q >> (BYTES_PER_CLK * 8);
          beat_q <= beat_q + BEAT_W'(1);
          if (last_beat_c) begin
            state_q    <= OUT;
            hash_q     <= hash_d;
            hash_val_q <= 1'b1;
          end
        end
        OUT: begin
          if (hash_rdy_i) begin
            hash_val_q <= 1'b0;
            if (in_val_i && win_ok_c) begin
              state_q <= CALC;
              win_q   <= win_c;
              beat_q  <= '0;
              crc_q   <= {NPOLY{CRC_INIT}};
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CRC_HASH_STATS_EN
  logic [31:0] win_cnt_q;
  logic [31:0] drop_cnt_q;

  // Saturating counts of windows consumed at the input handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (in_val_i && in_rdy_o) begin
      if (win_ok_c) begin
        if (win_cnt_q != 32'hFFFF_FFFF) win_cnt_q <= win_cnt_q + 32'd1;
      end else begin
        if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign win_cnt_o  = win_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_crc_hash_seq.sv
// Self-checking bench for crc_hash_seq (BF_N=9, 4 bytes/clk, 2 CRC engines, 5x12-bit hashes).
module tb_crc_hash_seq;

  localparam int unsigned BF_N  = 9;
  localparam int unsigned MAX_S = 32;
  localparam int unsigned NPOLY = 2;
  localparam int unsigned BPC   = 4;
  localparam int unsigned HCNT  = 5;
  localparam int unsigned HW    = 12;
  localparam int unsigned NBEAT = 3;

  logic                 clk;
  logic                 rst_n;
  logic [MAX_S*8-1:0]   symbs;
  logic [MAX_S-1:0]     vals;
  logic                 in_val;
  logic                 in_rdy_o;
  logic [HCNT*HW-1:0]   hash_o;
  logic                 hash_val_o;
  logic                 hash_rdy;
`ifdef CRC_HASH_STATS_EN
  logic [31:0]          win_cnt;
  logic [31:0]          drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_en = 0;

  crc_hash_seq #(
    .BF_N(BF_N), .MAX_S(MAX_S), .NPOLY(NPOLY), .BYTES_PER_CLK(BPC),
    .HASH_CNT(HCNT), .HASH_WIDTH(HW)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .symbs_data_i    (symbs),
    .symbs_data_val_i(vals),
    .in_val_i        (in_val),
    .in_rdy_o        (in_rdy_o),
    .hash_o          (hash_o),
    .hash_val_o      (hash_val_o),
    .hash_rdy_i      (hash_rdy)
`ifdef CRC_HASH_STATS_EN
    ,
    .win_cnt_o       (win_cnt),
    .drop_cnt_o      (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Textbook CRC-32: MSB-first shift register fed with bit-reversed bytes, result reflected.
  function automatic logic [31:0] ref_crc(input logic [71:0] w, input logic [31:0] poly);
    logic [31:0] r;
    logic [31:0] rr;
    logic [7:0]  d;
    logic        fb;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      d = w[i*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        fb = r[31] ^ d[b];
        r  = {r[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      end
    end
    for (int b = 0; b < 32; b++) rr[b] = r[31-b];
    return rr ^ 32'hFFFF_FFFF;
  endfunction

  function automatic logic [59:0] model_hash(input logic [71:0] w);
    logic [63:0] all;
    logic [59:0] h;
    all = {ref_crc(w, 32'h04C1_1DB7), ref_crc(w, 32'h1EDC_6F41)};
    for (int k = 0; k < 5; k++) h[k*12 +: 12] = all[63-k*12 -: 12];
    return h;
  endfunction

  // Reference model state
  bit          pend_v = 0;
  logic [59:0] pend_hash = '0;
  int          pend_due = 0;
  logic [59:0] last_hash = '0;
  int          n_ok = 0;
  int          n_out = 0;
  logic [31:0] exp_win = 0;
  logic [31:0] exp_drop = 0;

  always @(negedge clk) begin
    logic        exp_val;
    logic        exp_rdy;
    logic [71:0] w;
    logic        ok;
    if (!rst_n) begin
      chk("rst_hash_val", 64'(hash_val_o), 64'd0);
      chk("rst_hash", 64'(hash_o), 64'd0);
      pend_v    = 0;
      last_hash = '0;
      n_ok      = n_out;
      exp_win   = 0;
      exp_drop  = 0;
    end else begin
      exp_val = pend_v && (cyc >= pend_due);
      exp_rdy = !pend_v ? 1'b1 : (exp_val ? hash_rdy : 1'b0);
      chk("hash_val", 64'(hash_val_o), 64'(exp_val));
      chk("hash", 64'(hash_o), 64'(exp_val ? pend_hash : last_hash));
      chk("in_rdy", 64'(in_rdy_o), 64'(exp_rdy));
`ifdef CRC_HASH_STATS_EN
      chk("win_cnt", 64'(win_cnt), 64'(exp_win));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif
      if (exp_val) last_hash = pend_hash;
      if (exp_val && hash_rdy) begin
        pend_v = 0;
        n_out++;
      end
      if (in_val && exp_rdy) begin
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = symbs[(31-i)*8 +: 8];
        ok = &vals[31:23];
        if (ok) begin
          pend_v    = 1;
          pend_hash = model_hash(w);
          pend_due  = cyc + 1 + NBEAT;
          n_ok++;
          if (exp_win != 32'hFFFF_FFFF) exp_win++;
        end else if (exp_drop != 32'hFFFF_FFFF) begin
          exp_drop++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) hash_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic offer(input logic [71:0] w, input logic [8:0] okmask);
    bit acc;
    acc = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) symbs[j*32 +: 32] = $urandom;
    for (int i = 0; i < 9; i++) symbs[(31-i)*8 +: 8] = w[i*8 +: 8];
    vals        = $urandom;
    vals[31:23] = okmask;
    in_val      = 1'b1;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      if (rst_n && in_rdy_o) acc = 1;
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  logic [71:0] str9;
  logic [71:0] w2;
  int          lat;

  initial begin
    rst_n    = 1'b0;
    symbs    = '0;
    vals     = '0;
    in_val   = 1'b0;
    hash_rdy = 1'b0;
    for (int i = 0; i < 9; i++) str9[i*8 +: 8] = 8'h31 + 8'(i);

    chk("model_crc0", 64'(ref_crc(str9, 32'h04C1_1DB7)), 64'h0000_0000_CBF4_3926);
    chk("model_crc1", 64'(ref_crc(str9, 32'h1EDC_6F41)), 64'h0000_0000_E306_9283);
    chk("model_hash", 64'(model_hash(str9)), 64'h0928_3062_6E43_9CBF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Window with one byte not valid: consumed, never hashed
    offer(str9, 9'b1_1110_1111);
`ifdef CRC_HASH_STATS_EN
    chk("drop_cnt_lit", 64'(drop_cnt), 64'd1);
    chk("win_cnt_lit", 64'(win_cnt), 64'd0);
`endif
    repeat (8) @(posedge clk);
    chk("drop_no_val", 64'(hash_val_o), 64'd0);

    // "123456789": known CRC-32 / CRC-32C values, partial last beat
    offer(str9, 9'h1FF);
    lat = -1;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (hash_val_o) lat = n;
    end
    chk("latency", 64'(lat), 64'(NBEAT));
    chk("hash_lit", 64'(hash_o), 64'h0928_3062_6E43_9CBF);
    chk("hash0_lit", 64'(hash_o[11:0]), 64'h0CBF);

    // Output held 20 cycles while a window waits; released with in_val high
    w2 = 72'h49_48_47_46_45_44_43_42_41;
    fork
      offer(w2, 9'h1FF);
      begin
        repeat (20) @(posedge clk);
        #1 hash_rdy = 1'b1;
      end
    join
    repeat (8) @(posedge clk);

    // Reset pulse in the middle of CALC
    offer(str9 ^ 72'h0F, 9'h1FF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_val", 64'(hash_val_o), 64'd0);
    chk("midrst_hash", 64'(hash_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Random stream with random consumer backpressure
    rand_en = 1;
    for (int t = 0; t < 200; t++) begin
      logic [71:0] rw;
      logic [8:0]  m;
      rw = {$urandom, $urandom, $urandom};
      m  = 9'h1FF;
      if ($urandom_range(0, 7) == 0) m[$urandom_range(0, 8)] = 1'b0;
      offer(rw, m);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_en = 0;
    @(posedge clk);
    #1 hash_rdy = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("all_windows_out", 64'(n_out), 64'(n_ok));
    chk("nothing_pending", 64'(pend_v), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
